calendar_date_counter: RTL and testbench

- Upstream stage of the weekday calculator. Holds the current date as BCD year (3 digits), month and day.
- Advances one day per midnight tick from the time-of-day counter.
- Supports manual date setting by up/down button pulses, with month-length and leap-year handling.
- Outputs feed the weekday calculator directly; `date_upd` marks each new stable date.

---
 rtl/calendar_date_counter.sv | 199 +++++++++++++++++++
 tb/tb_calendar_date_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// Calendar date counter: BCD year/month/day with day-tick advance,
// manual up/down setting, month-length and leap-year handling.
// Month and year edits pass through a one-cycle CLAMP state that pulls
// the day back into range before date_upd announces the new date.
module calendar_date_counter #(
  parameter logic [11:0] RESET_YEAR  = 12'h025,
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [7:0]  RESET_DAY   = 8'h01,
  parameter logic [11:0] YEAR_MAX    = 12'h199
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        day_tick,
  input  logic        set_mode,
  input  logic [1:0]  set_sel,
  input  logic        set_up,
  input  logic        set_down,
  output logic [11:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic        leap,
  output logic        date_upd
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLAMP = 1'b1;

  localparam logic [1:0] SEL_DAY   = 2'd0;
  localparam logic [1:0] SEL_MONTH = 2'd1;
  localparam logic [1:0] SEL_YEAR  = 2'd2;

  logic [0:0]  state_q, state_d;
  logic [11:0] year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic        leap_q, leap_d;
  logic        upd_q, upd_d;
  logic [7:0]  cur_len;
  logic        set_evt;

  // Leap test straight from BCD digits: mod-4 of a decimal number only
  // depends on the tens parity and the ones digit; 2100 is the one
  // century year in range that is not leap.
  function automatic logic bcd_is_leap(input logic [11:0] y);
    logic [3:0] tens;
    logic [3:0] ones;
    logic       r;
    tens = y[7:4];
    ones = y[3:0];
    r = (!tens[0] && (ones == 4'd0 || ones == 4'd4 || ones == 4'd8)) ||
        ( tens[0] && (ones == 4'd2 || ones == 4'd6));
    return r && (y != 12'h100);
  endfunction

  function automatic logic [7:0] month_length(input logic [7:0] m, input logic lp);
    logic [7:0] r;
    case (m)
      8'h02:                      r = lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] x);
    logic [7:0] r;
    if (x[3:0] == 4'd9) r = {x[7:4] + 4'd1, 4'd0};
    else                r = {x[7:4], x[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] x);
    logic [7:0] r;
    if (x[3:0] == 4'd0) r = {x[7:4] - 4'd1, 4'd9};
    else                r = {x[7:4], x[3:0] - 4'd1};
    return r;
  endfunction

  // Year increment with wrap YEAR_MAX -> 000.
  function automatic logic [11:0] year_inc(input logic [11:0] y);
    logic [11:0] r;
    r = y;
    if (y == YEAR_MAX) begin
      r = 12'h000;
    end else if (y[3:0] != 4'd9) begin
      r[3:0] = y[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (y[7:4] != 4'd9) begin
        r[7:4] = y[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = y[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // Year decrement with wrap 000 -> YEAR_MAX.
  function automatic logic [11:0] year_dec(input logic [11:0] y);
    logic [11:0] r;
    r = y;
    if (y == 12'h000) begin
      r = YEAR_MAX;
    end else if (y[3:0] != 4'd0) begin
      r[3:0] = y[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (y[7:4] != 4'd0) begin
        r[7:4] = y[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = y[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  assign cur_len = month_length(month_q, leap_q);
  assign set_evt = set_mode && (set_up ^ set_down);
  assign leap_d  = bcd_is_leap(year_d);

  // Next-date selection: clamp first, then day_tick, then manual set.
  always_comb begin
    // NOTE: every output of this block gets a default up front so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    upd_d   = 1'b0;

    if (state_q == ST_CLAMP) begin
      // Year/month already moved; leap_q matches the new year here.
      if (day_q > cur_len) day_d = cur_len;
      upd_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (!set_mode && day_tick) begin
      upd_d = 1'b1;
      if (day_q == cur_len) begin
        day_d = 8'h01;
        if (month_q == 8'h12) begin
          month_d = 8'h01;
          year_d  = year_inc(year_q);
        end else begin
          month_d = bcd2_inc(month_q);
        end
      end else begin
        day_d = bcd2_inc(day_q);
      end
    end else if (set_evt) begin
      case (set_sel)
        SEL_DAY: begin
          upd_d = 1'b1;
          if (set_up) day_d = (day_q == cur_len) ? 8'h01 : bcd2_inc(day_q);
          else        day_d = (day_q == 8'h01)   ? cur_len : bcd2_dec(day_q);
        end
        SEL_MONTH: begin
          if (set_up) month_d = (month_q == 8'h12) ? 8'h01 : bcd2_inc(month_q);
          else        month_d = (month_q == 8'h01) ? 8'h12 : bcd2_dec(month_q);
          state_d = ST_CLAMP;
        end
        SEL_YEAR: begin
          year_d  = set_up ? year_inc(year_q) : year_dec(year_q);
          state_d = ST_CLAMP;
        end
        default: ;
      endcase
    end
  end

  // Date, leap flag, update strobe and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      year_q  <= RESET_YEAR;
      month_q <= RESET_MONTH;
      day_q   <= RESET_DAY;
      leap_q  <= bcd_is_leap(RESET_YEAR);
      upd_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      leap_q  <= leap_d;
      upd_q   <= upd_d;
    end
  end

  assign year_bcd  = year_q;
  assign month_bcd = month_q;
  assign day_bcd   = day_q;
  assign leap      = leap_q;
  assign date_upd  = upd_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Testbench for calendar_date_counter: a binary reference model computes
// the expected registered outputs for every driven cycle, pushes them to a
// scoreboard queue, and each cycle's DUT outputs are popped and compared.
module tb_calendar_date_counter;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        day_tick = 1'b0;
  logic        set_mode = 1'b0;
  logic [1:0]  set_sel  = 2'd3;
  logic        set_up   = 1'b0;
  logic        set_down = 1'b0;
  logic [11:0] year_bcd;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic        leap;
  logic        date_upd;

  typedef struct packed {
    logic [11:0] y;
    logic [7:0]  m;
    logic [7:0]  d;
    logic        l;
    logic        u;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, kept in plain binary.
  int my, mm, md;
  bit m_clamp;

  always #5 clk = ~clk;

  calendar_date_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .day_tick  (day_tick),
    .set_mode  (set_mode),
    .set_sel   (set_sel),
    .set_up    (set_up),
    .set_down  (set_down),
    .year_bcd  (year_bcd),
    .month_bcd (month_bcd),
    .day_bcd   (day_bcd),
    .leap      (leap),
    .date_upd  (date_upd)
  );

  function automatic bit m_leap(int y);
    return (y % 4 == 0) && (y != 100);
  endfunction

  function automatic int m_len(int mo, int y);
    case (mo)
      2:            return m_leap(y) ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  function automatic obs_t m_obs(bit upd);
    obs_t o;
    o.y = {4'(my / 100), 4'((my / 10) % 10), 4'(my % 10)};
    o.m = {4'(mm / 10), 4'(mm % 10)};
    o.d = {4'(md / 10), 4'(md % 10)};
    o.l = m_leap(my);
    o.u = upd;
    return o;
  endfunction

  task automatic model_reset();
    my = 25; mm = 1; md = 1; m_clamp = 0;
    exp_q.delete();
  endtask

  // One clock of the reference model for the given sampled inputs.
  task automatic model_step(input bit tick, input bit mode, input logic [1:0] sel,
                            input bit up, input bit dn, output obs_t e);
    bit upd;
    upd = 0;
    if (m_clamp) begin
      if (md > m_len(mm, my)) md = m_len(mm, my);
      upd = 1;
      m_clamp = 0;
    end else if (!mode && tick) begin
      upd = 1;
      if (md < m_len(mm, my)) begin
        md++;
      end else begin
        md = 1;
        mm++;
        if (mm > 12) begin
          mm = 1;
          my = (my == 199) ? 0 : my + 1;
        end
      end
    end else if (mode && (up != dn) && sel != 2'd3) begin
      case (sel)
        2'd0: begin
          upd = 1;
          if (up) md = (md == m_len(mm, my)) ? 1 : md + 1;
          else    md = (md == 1) ? m_len(mm, my) : md - 1;
        end
        2'd1: begin
          if (up) mm = (mm == 12) ? 1 : mm + 1;
          else    mm = (mm == 1) ? 12 : mm - 1;
          m_clamp = 1;
        end
        default: begin
          if (up) my = (my == 199) ? 0 : my + 1;
          else    my = (my == 0) ? 199 : my - 1;
          m_clamp = 1;
        end
      endcase
    end
    e = m_obs(upd);
  endtask

  // Drive one cycle of pulses (called just after a falling edge), then
  // compare the outputs registered at the following rising edge.
  task automatic drive_cycle(input bit tick, input bit up, input bit dn, input string name);
    obs_t e;
    obs_t a;
    day_tick = tick;
    set_up   = up;
    set_down = dn;
    model_step(tick, set_mode, set_sel, up, dn, e);
    exp_q.push_back(e);
    @(negedge clk);
    day_tick = 1'b0;
    set_up   = 1'b0;
    set_down = 1'b0;
    a = {year_bcd, month_bcd, day_bcd, leap, date_upd};
    e = exp_q.pop_front();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h-%h-%h leap=%b upd=%b, want %h-%h-%h leap=%b upd=%b",
               name, a.y, a.m, a.d, a.l, a.u, e.y, e.m, e.d, e.l, e.u);
    end
  endtask

  // Button press followed by two quiet cycles (covers clamp and pulse end).
  task automatic press(input logic [1:0] sel, input bit up, input bit dn, input string name);
    set_sel = sel;
    drive_cycle(0, up, dn, name);
    drive_cycle(0, 0, 0, {name, "_c1"});
    drive_cycle(0, 0, 0, {name, "_c2"});
  endtask

  task automatic tick_day(input string name);
    drive_cycle(1, 0, 0, name);
    drive_cycle(0, 0, 0, {name, "_idle"});
  endtask

  task automatic nav_year(input int target, input bit up);
    for (int i = 0; i < 200 && my != target; i++) press(2'd2, up, !up, "year_nav");
  endtask

  task automatic test_reset();
    obs_t a;
    rst_n = 1'b0;
    set_mode = 1'b0;
    #12;
    a = {year_bcd, month_bcd, day_bcd, leap, date_upd};
    vectors++;
    if (a !== {12'h025, 8'h01, 8'h01, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got %h, want %h", a, {12'h025, 8'h01, 8'h01, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_cycle(0, 0, 0, "reset_idle");

    // Reset asserted while a month edit sits in CLAMP.
    set_mode = 1'b1;
    set_sel  = 2'd1;
    drive_cycle(0, 1, 0, "pre_reset_month_up");
    rst_n = 1'b0;
    #1;
    a = {year_bcd, month_bcd, day_bcd, leap, date_upd};
    vectors++;
    if (a !== {12'h025, 8'h01, 8'h01, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_clamp: got %h, want %h", a, {12'h025, 8'h01, 8'h01, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_mode = 1'b0;
    drive_cycle(0, 0, 0, "post_reset_no_clamp");
    drive_cycle(0, 0, 0, "post_reset_idle");
  endtask

  task automatic test_day_tick();
    set_mode = 1'b1;
    press(2'd0, 0, 1, "day_down_wrap_jan");     // 025-01-31
    set_mode = 1'b0;
    tick_day("tick_jan31");                     // 025-02-01
    set_mode = 1'b1;
    press(2'd2, 0, 1, "year_down_024");         // 024-02-01
    press(2'd0, 0, 1, "day_down_wrap_feb_leap");// 024-02-29
    press(2'd0, 0, 1, "day_down_28");           // 024-02-28
    set_mode = 1'b0;
    tick_day("tick_feb28_leap");                // 024-02-29
    tick_day("tick_feb29");                     // 024-03-01
  endtask

  task automatic test_century();
    set_mode = 1'b1;
    nav_year(100, 1);
    press(2'd1, 0, 1, "month_down_feb_2100");   // 100-02-01
    press(2'd0, 0, 1, "day_down_wrap_2100");    // 100-02-28
    set_mode = 1'b0;
    tick_day("tick_feb28_2100");                // 100-03-01
    set_mode = 1'b1;
    nav_year(199, 1);
    for (int i = 0; i < 9; i++) press(2'd1, 1, 0, "month_up_nav");
    press(2'd0, 0, 1, "day_down_dec31");        // 199-12-31
    set_mode = 1'b0;
    tick_day("tick_year_max_rollover");         // 000-01-01
    set_mode = 1'b1;
    press(2'd2, 0, 1, "year_down_wrap");        // 199-01-01
    press(2'd2, 1, 0, "year_up_wrap");          // 000-01-01
  endtask

  task automatic test_month_clamp();
    set_mode = 1'b1;
    nav_year(25, 1);
    press(2'd1, 1, 0, "month_up_feb");
    press(2'd1, 1, 0, "month_up_mar");
    press(2'd0, 0, 1, "day_down_mar31");        // 025-03-31
    press(2'd1, 0, 1, "month_clamp_28");        // 025-02-28
    press(2'd2, 0, 1, "year_down_024_feb28");   // 024-02-28
    press(2'd1, 1, 0, "month_up_mar28");
    for (int i = 0; i < 3; i++) press(2'd0, 1, 0, "day_up_nav");
    press(2'd1, 0, 1, "month_clamp_29");        // 024-02-29
  endtask

  task automatic test_year_clamp();
    set_mode = 1'b1;
    press(2'd2, 1, 0, "year_clamp_feb29");      // 025-02-28
    press(2'd0, 1, 0, "day_up_wrap_feb");       // 025-02-01
  endtask

  task automatic test_ignored();
    set_mode = 1'b1;
    set_sel  = 2'd0;
    drive_cycle(1, 0, 0, "tick_in_set_mode");
    press(2'd0, 1, 1, "both_buttons");
    press(2'd3, 1, 0, "sel_none_up");
    press(2'd3, 0, 1, "sel_none_down");
    set_mode = 1'b0;
    press(2'd0, 1, 0, "up_outside_set_mode");
  endtask

  task automatic test_back_to_back();
    set_mode = 1'b1;
    set_sel  = 2'd1;
    drive_cycle(0, 1, 0, "month_up_first");
    drive_cycle(0, 1, 0, "month_up_during_clamp");
    drive_cycle(0, 0, 0, "month_up_after");
    drive_cycle(0, 1, 0, "month_up_again");
    drive_cycle(0, 0, 0, "month_up_again_clamp");
    set_mode = 1'b0;
    drive_cycle(1, 0, 0, "tick_with_mode_drop");
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, "tick_consecutive");
    drive_cycle(0, 0, 0, "tick_consecutive_end");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_day_tick();
    test_century();
    test_month_clamp();
    test_year_clamp();
    test_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
